// File: rtl/symbol_unpacker_if.sv
// Byte-in / symbol-out port bundle of symbol_unpacker.
// The master modport is the byte producer (and symbol observer); the slave modport is the unpacker.
interface symbol_unpacker_if #(
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic [7:0]                   in_data;
  logic                         in_ready;
  logic [1:0]                   num;
  logic                         num_valid;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport master (
    output in_valid, in_data,
    input  in_ready, num, num_valid, level
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, num, num_valid, level
  );
endinterface

// File: rtl/symbol_unpacker.sv
// Byte FIFO feeding a shifter that emits one 2-bit symbol per clock to the sequence detector.
// Optional macro UNPACK_HOLD_EN: on underflow num holds the last symbol instead of dropping to 0.
module symbol_unpacker #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  symbol_unpacker_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  state_e        state_q;
  logic [1:0]    idx_q;
  logic [7:0]    shreg_q;
  logic [1:0]    num_q;
  logic          num_valid_q;

  logic          push;
  logic          pop;
  logic [7:0]    head;

  function automatic logic [1:0] pick(input logic [7:0] b, input logic [1:0] i);
    logic [1:0] k;
    k = MSB_FIRST ? (2'd3 - i) : i;
    return b[{k, 1'b0} +: 2];
  endfunction

  // Ready depends only on the registered level, so a full FIFO refuses even when it pops.
  assign bus.in_ready = (level_q != LW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (level_q != '0) && ((state_q == ST_IDLE) || (idx_q == 2'd3));
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default first so every path assigns level_d and no latch is inferred.
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // NOTE: storage has no reset; level/pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      shreg_q     <= 8'h00;
      num_q       <= 2'b00;
      num_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;

      if (pop) begin
        state_q     <= ST_SHIFT;
        shreg_q     <= head;
        idx_q       <= 2'd0;
        num_q       <= pick(head, 2'd0);
        num_valid_q <= 1'b1;
      end else if ((state_q == ST_SHIFT) && (idx_q != 2'd3)) begin
        idx_q       <= idx_q + 2'd1;
        num_q       <= pick(shreg_q, idx_q + 2'd1);
        num_valid_q <= 1'b1;
      end else begin
        // Underflow: the idle symbol aborts any partial match in the detector.
        state_q     <= ST_IDLE;
        num_valid_q <= 1'b0;
`ifdef UNPACK_HOLD_EN
        num_q       <= num_q;
`else
        num_q       <= 2'b00;
`endif
      end
    end
  end

  assign bus.num       = num_q;
  assign bus.num_valid = num_valid_q;
  assign bus.level     = level_q;

endmodule
